// File: rtl/id_operand_reader_pkg.sv
// Shared widths, the x0 address and the writer-match helper for the ID operand reader.
// Forwarding is enabled by defining ID_FWD_EN; the default build has no forwarding.
package id_operand_reader_pkg;

    localparam int P_XLEN  = 32;
    localparam int P_RADDR = 5;

    localparam logic [P_RADDR-1:0] X0 = '0;

    // A writer targeting x0 never matches any source.
    function automatic logic wr_hit(
        input logic               we,
        input logic [P_RADDR-1:0] wr,
        input logic [P_RADDR-1:0] src
    );
        return we && (wr == src) && (wr != X0);
    endfunction

endpackage

// File: rtl/id_operand_reader_fwd_mux.sv
// Per-operand writer match, priority select and hazard detect.
// ID_FWD_EN selects forwarding; otherwise any in-flight writer match is a hazard.
module fwd_mux
    import id_operand_reader_pkg::*;
#(
    parameter int XLEN  = P_XLEN,
    parameter int RADDR = P_RADDR
) (
    input  logic [RADDR-1:0] i_src,
    input  logic             i_used,
    input  logic [XLEN-1:0]  i_rd,
    input  logic             i_ex_we,
    input  logic             i_ex_load,
    input  logic [RADDR-1:0] i_ex_wR,
    input  logic [XLEN-1:0]  i_ex_d,
    input  logic             i_mem_we,
    input  logic [RADDR-1:0] i_mem_wR,
    input  logic [XLEN-1:0]  i_mem_d,
    input  logic             i_wb_we,
    input  logic [RADDR-1:0] i_wb_wR,
    input  logic [XLEN-1:0]  i_wb_d,
    output logic [XLEN-1:0]  o_data,
    output logic             o_haz
);

    logic w_zero;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_zero    = (i_src == X0);
    assign w_ex_hit  = wr_hit(i_ex_we, i_ex_wR, i_src);
    assign w_mem_hit = wr_hit(i_mem_we, i_mem_wR, i_src);
    assign w_wb_hit  = wr_hit(i_wb_we, i_wb_wR, i_src);

`ifdef ID_FWD_EN
    // WB must be forwarded: the RF write only lands at the clock edge.
    always_comb begin
        o_data = i_rd;
        if (w_zero)
            o_data = '0;
        else if (w_ex_hit && !i_ex_load)
            o_data = i_ex_d;
        else if (w_mem_hit)
            o_data = i_mem_d;
        else if (w_wb_hit)
            o_data = i_wb_d;
    end

    assign o_haz = i_used && w_ex_hit && i_ex_load;
`else
    logic w_unused;

    assign o_data   = w_zero ? '0 : i_rd;
    assign o_haz    = i_used && (w_ex_hit || w_mem_hit || w_wb_hit);
    assign w_unused = ^{i_ex_load, i_ex_d, i_mem_d, i_wb_d};
`endif

endmodule

// File: rtl/id_operand_reader.sv
// Decode-stage RF read, RAW hazard resolution and ID/EX register.
// Define ID_FWD_EN for EX/MEM/WB forwarding; default build stalls on any in-flight writer.
module id_operand_reader
    import id_operand_reader_pkg::*;
#(
    parameter int XLEN  = P_XLEN,
    parameter int RADDR = P_RADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RADDR-1:0] id_wR,
    input  logic             id_rf_we,
    output logic [RADDR-1:0] rR1,
    output logic [RADDR-1:0] rR2,
    input  logic [XLEN-1:0]  rD1,
    input  logic [XLEN-1:0]  rD2,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic [RADDR-1:0] ex_wR,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_rf_we,
    input  logic [RADDR-1:0] mem_wR,
    input  logic [XLEN-1:0]  mem_wD,
    input  logic             wb_rf_we,
    input  logic [RADDR-1:0] wb_wR,
    input  logic [XLEN-1:0]  wb_wD,
    input  logic             flush,
    output logic             stall,
    output logic             idex_valid,
    output logic [XLEN-1:0]  idex_op1,
    output logic [XLEN-1:0]  idex_op2,
    output logic [RADDR-1:0] idex_wR,
    output logic             idex_rf_we,
    output logic [31:0]      stall_cnt
);

    logic [XLEN-1:0]  w_op1;
    logic [XLEN-1:0]  w_op2;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_stall;

    logic             r_valid;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [RADDR-1:0] r_wR;
    logic             r_we;
    logic [31:0]      r_stall_cnt;

    assign rR1 = id_rs1;
    assign rR2 = id_rs2;

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd1 (
        .i_src     (id_rs1),
        .i_used    (id_rs1_used),
        .i_rd      (rD1),
        .i_ex_we   (ex_rf_we),
        .i_ex_load (ex_is_load),
        .i_ex_wR   (ex_wR),
        .i_ex_d    (ex_result),
        .i_mem_we  (mem_rf_we),
        .i_mem_wR  (mem_wR),
        .i_mem_d   (mem_wD),
        .i_wb_we   (wb_rf_we),
        .i_wb_wR   (wb_wR),
        .i_wb_d    (wb_wD),
        .o_data    (w_op1),
        .o_haz     (w_haz1)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd2 (
        .i_src     (id_rs2),
        .i_used    (id_rs2_used),
        .i_rd      (rD2),
        .i_ex_we   (ex_rf_we),
        .i_ex_load (ex_is_load),
        .i_ex_wR   (ex_wR),
        .i_ex_d    (ex_result),
        .i_mem_we  (mem_rf_we),
        .i_mem_wR  (mem_wR),
        .i_mem_d   (mem_wD),
        .i_wb_we   (wb_rf_we),
        .i_wb_wR   (wb_wR),
        .i_wb_d    (wb_wD),
        .o_data    (w_op2),
        .o_haz     (w_haz2)
    );

    // Flush wins: a killed instruction never stalls the front end.
    assign w_stall = id_valid && (w_haz1 || w_haz2) && !flush;
    assign stall   = w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_wR        <= '0;
            r_we        <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush || w_stall) begin
                r_valid <= 1'b0;
                r_we    <= 1'b0;
            end else begin
                r_valid <= id_valid;
                r_we    <= id_rf_we && id_valid;
                r_op1   <= w_op1;
                r_op2   <= w_op2;
                r_wR    <= id_wR;
            end
        end
    end

    assign idex_valid = r_valid;
    assign idex_op1   = r_op1;
    assign idex_op2   = r_op2;
    assign idex_wR    = r_wR;
    assign idex_rf_we = r_we;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_operand_reader.sv
// Directed bench for id_operand_reader with a spec-level reference model.
// Works with and without ID_FWD_EN defined.
module tb_id_operand_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_wR = '0;
    logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_rf_we = 1'b0;
    logic [4:0]  rR1, rR2;
    logic [31:0] rD1 = '0, rD2 = '0;
    logic        ex_rf_we = 1'b0, ex_is_load = 1'b0;
    logic [4:0]  ex_wR = '0;
    logic [31:0] ex_result = '0;
    logic        mem_rf_we = 1'b0;
    logic [4:0]  mem_wR = '0;
    logic [31:0] mem_wD = '0;
    logic        wb_rf_we = 1'b0;
    logic [4:0]  wb_wR = '0;
    logic [31:0] wb_wD = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        idex_valid, idex_rf_we;
    logic [31:0] idex_op1, idex_op2;
    logic [4:0]  idex_wR;
    logic [31:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;
    logic s_seen;
    int   n_st;
    logic [31:0] cnt0;

`ifdef ID_FWD_EN
    localparam int FWD = 1;
    localparam int N_STALL = 1;
`else
    localparam int FWD = 0;
    localparam int N_STALL = 7;
`endif

    id_operand_reader dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_wR(id_wR), .id_rf_we(id_rf_we),
        .rR1(rR1), .rR2(rR2), .rD1(rD1), .rD2(rD2),
        .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .ex_wR(ex_wR), .ex_result(ex_result),
        .mem_rf_we(mem_rf_we), .mem_wR(mem_wR), .mem_wD(mem_wD),
        .wb_rf_we(wb_rf_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
        .flush(flush), .stall(stall),
        .idex_valid(idex_valid), .idex_op1(idex_op1), .idex_op2(idex_op2),
        .idex_wR(idex_wR), .idex_rf_we(idex_rf_we), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: operand and hazard rules written directly from the rules.
    function automatic logic [31:0] m_opnd(input logic [4:0] s, input logic [31:0] rd);
        if (s == 0) return 32'h0;
        if (FWD != 0) begin
            if (ex_rf_we && ex_wR == s && !ex_is_load) return ex_result;
            if (mem_rf_we && mem_wR == s) return mem_wD;
            if (wb_rf_we && wb_wR == s) return wb_wD;
        end
        return rd;
    endfunction

    function automatic logic m_src_haz(input logic [4:0] s, input logic u);
        if (!u || s == 0) return 1'b0;
        if (FWD != 0) return ex_rf_we && ex_is_load && ex_wR == s;
        return (ex_rf_we && ex_wR == s) || (mem_rf_we && mem_wR == s) ||
               (wb_rf_we && wb_wR == s);
    endfunction

    function automatic logic m_stall();
        return id_valid && !flush &&
               (m_src_haz(id_rs1, id_rs1_used) || m_src_haz(id_rs2, id_rs2_used));
    endfunction

    logic        m_valid, m_we;
    logic [31:0] m_op1, m_op2, m_cnt;
    logic [4:0]  m_wR;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_we <= 1'b0; m_op1 <= '0; m_op2 <= '0;
            m_wR <= '0; m_cnt <= '0;
        end else begin
            if (m_stall()) m_cnt <= m_cnt + 1;
            if (flush || m_stall()) begin
                m_valid <= 1'b0;
                m_we    <= 1'b0;
            end else begin
                m_valid <= id_valid;
                m_we    <= id_rf_we && id_valid;
                m_op1   <= m_opnd(id_rs1, rD1);
                m_op2   <= m_opnd(id_rs2, rD2);
                m_wR    <= id_wR;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("rR1", {27'b0, rR1}, {27'b0, id_rs1});
            chk("rR2", {27'b0, rR2}, {27'b0, id_rs2});
            chk("stall", {31'b0, stall}, {31'b0, m_stall()});
            chk("idex_valid", {31'b0, idex_valid}, {31'b0, m_valid});
            chk("idex_rf_we", {31'b0, idex_rf_we}, {31'b0, m_we});
            chk("idex_op1", idex_op1, m_op1);
            chk("idex_op2", idex_op2, m_op2);
            chk("idex_wR", {27'b0, idex_wR}, {27'b0, m_wR});
            chk("stall_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        s_seen = stall;
        if (s_seen) n_st++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        ex_rf_we = 0; ex_is_load = 0; ex_wR = 0; ex_result = 0;
        mem_rf_we = 0; mem_wR = 0; mem_wD = 0;
        wb_rf_we = 0; wb_wR = 0; wb_wD = 0;
        flush = 0;
    endtask

    task automatic instr(input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic [4:0] w);
        id_valid = 1; id_rs1 = s1; id_rs1_used = u1;
        id_rs2 = s2; id_rs2_used = u2; id_wR = w; id_rf_we = 1;
    endtask

    initial begin
        #1;
        chk("rst_valid", {31'b0, idex_valid}, 32'h0);
        chk("rst_op1", idex_op1, 32'h0);
        chk("rst_cnt", stall_cnt, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        chk_en = 1;

        // Plain RF read
        instr(5'd3, 1, 5'd0, 1, 5'd1); rD1 = 32'h11;
        tick();
        chk("t1_op1", idex_op1, 32'h11);
        chk("t1_valid", {31'b0, idex_valid}, 32'h1);
        chk("t1_op2", idex_op2, 32'h0);

        // EX and MEM both writing x5, draining through the pipe
        n_st = 0;
        instr(5'd5, 1, 5'd0, 0, 5'd2); rD1 = 32'h5555;
        ex_rf_we = 1; ex_wR = 5; ex_result = 32'hAAAA;
        mem_rf_we = 1; mem_wR = 5; mem_wD = 32'hBBBB;
        tick();
        chk("t2_first_op1", idex_op1, FWD != 0 ? 32'hAAAA : 32'h11);
        ex_rf_we = 0; mem_wD = 32'hAAAA; wb_rf_we = 1; wb_wR = 5; wb_wD = 32'hBBBB;
        tick();
        mem_rf_we = 0; wb_wD = 32'hAAAA;
        tick();
        idle_wr(); rD1 = 32'hAAAA;
        tick();
        chk("t2_op1", idex_op1, 32'hAAAA);
        chk("t2_stalls", n_st, FWD != 0 ? 0 : 3);

        // WB-only writer; RF read still old
        instr(5'd0, 1, 5'd7, 1, 5'd3); rD2 = 32'h0;
        wb_rf_we = 1; wb_wR = 7; wb_wD = 32'h1234;
        tick();
        idle_wr(); rD2 = 32'h1234;
        tick();
        chk("t3_op2", idex_op2, 32'h1234);

        // Load-use
        cnt0 = stall_cnt;
        instr(5'd9, 1, 5'd0, 1, 5'd4); rD1 = 32'h0;
        ex_rf_we = 1; ex_is_load = 1; ex_wR = 9; ex_result = 32'hDEAD;
        tick();
        chk("t4_stall", {31'b0, s_seen}, 32'h1);
        chk("t4_bubble", {31'b0, idex_valid}, 32'h0);
        chk("t4_cnt", stall_cnt, cnt0 + 1);
        ex_rf_we = 0; ex_is_load = 0;
        mem_rf_we = 1; mem_wR = 9; mem_wD = 32'h55;
        tick();
        if (FWD != 0) chk("t4_fwd_op1", idex_op1, 32'h55);
        mem_rf_we = 0; wb_rf_we = 1; wb_wR = 9; wb_wD = 32'h55;
        tick();
        idle_wr(); rD1 = 32'h55;
        tick();
        chk("t4_op1", idex_op1, 32'h55);

        // Flush beats load-use stall
        instr(5'd9, 1, 5'd0, 1, 5'd5);
        ex_rf_we = 1; ex_is_load = 1; ex_wR = 9; flush = 1;
        tick();
        chk("t5_stall", {31'b0, s_seen}, 32'h0);
        chk("t5_valid", {31'b0, idex_valid}, 32'h0);
        // Unused rs2 matching a load never stalls
        flush = 0;
        instr(5'd3, 1, 5'd9, 0, 5'd6); rD1 = 32'h33;
        tick();
        chk("t5_unused", {31'b0, s_seen}, 32'h0);
        chk("t5_op1", idex_op1, 32'h33);

        // Writers to x0 never forward, x0 reads zero
        idle_wr();
        instr(5'd0, 1, 5'd0, 1, 5'd7); rD1 = 32'hFFFF; rD2 = 32'hFFFF;
        ex_rf_we = 1; ex_wR = 0; ex_result = 32'hFFFF;
        mem_rf_we = 1; mem_wR = 0; mem_wD = 32'hFFFF;
        wb_rf_we = 1; wb_wR = 0; wb_wD = 32'hFFFF;
        tick();
        chk("t6_stall", {31'b0, s_seen}, 32'h0);
        chk("t6_op1", idex_op1, 32'h0);
        chk("t6_op2", idex_op2, 32'h0);
        chk("t6_cnt", stall_cnt, N_STALL);

        // Async reset in the middle of a stall
        idle_wr();
        instr(5'd9, 1, 5'd0, 0, 5'd8);
        ex_rf_we = 1; ex_is_load = 1; ex_wR = 9;
        tick();
        #2 rst = 1;
        #1;
        chk("t7_valid", {31'b0, idex_valid}, 32'h0);
        chk("t7_op1", idex_op1, 32'h0);
        chk("t7_op2", idex_op2, 32'h0);
        chk("t7_wR", {27'b0, idex_wR}, 32'h0);
        chk("t7_cnt", stall_cnt, 32'h0);
        @(negedge clk); #2;
        rst = 0;
        idle_wr(); id_valid = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/id_operand_reader.md
Name: id_operand_reader

Overview:
- Decode-stage read side of the 32x32 register file.
- Drives the RF asynchronous read addresses and resolves RAW hazards against in-flight writers (EX, MEM, WB) by forwarding or stalling.
- Registers resolved operands into the ID/EX pipeline register.
- Sits between the IF/ID register and the EX stage; the WB stage drives the RF write port.

Parameters:
- XLEN, 32, data width.
- RADDR, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1, id_rs2  in  5 each  source register addresses
- id_rs1_used, id_rs2_used  in  1 each  instruction reads that source
- id_wR  in  5  destination address
- id_rf_we  in  1  instruction writes RF
- rR1, rR2  out  5 each  RF read addresses, combinational = id_rs1/id_rs2
- rD1, rD2  in  32 each  RF read data (async)
- ex_rf_we, ex_is_load  in  1 each  EX-stage writer info
- ex_wR  in  5  EX destination
- ex_result  in  32  EX ALU result
- mem_rf_we  in  1  MEM-stage write enable
- mem_wR  in  5  MEM destination
- mem_wD  in  32  MEM write data
- wb_rf_we  in  1  WB-stage write enable (same signals as RF write port)
- wb_wR  in  5  WB destination
- wb_wD  in  32  WB write data
- flush  in  1  kill instruction in ID (branch taken)
- stall  out  1  hold PC and IF/ID, combinational
- idex_valid  out  1  registered
- idex_op1, idex_op2  out  32 each  registered
- idex_wR  out  5  registered
- idex_rf_we  out  1  registered
- stall_cnt  out  32  registered; cycles with stall=1

Behaviour:
- Reset (async): idex_valid=0, idex_op1/op2=0, idex_wR=0, idex_rf_we=0, stall_cnt=0.
- Operand select per source, priority high to low:
  - Address 0 gives 0.
  - EX match (ex_rf_we, ex_wR==src, !ex_is_load) gives ex_result.
  - MEM match gives mem_wD.
  - WB match gives wb_wD. Required because the RF write lands at the clock edge and the async read does not see it in the same cycle.
  - Otherwise rD.
- Writer with wR==0 never matches.
- Load-use hazard: id_valid and a used source matches ex_wR with ex_rf_we && ex_is_load && ex_wR!=0.
- stall = hazard && !flush. Flush has priority; the stalled instruction is killed.
- Stall sequence: 1 bubble cycle. Next cycle the load sits in MEM and is forwarded from mem_wD.
- ID/EX update each posedge, highest priority first:
  - flush: idex_valid=0, idex_rf_we=0.
  - else stall: bubble, same as flush.
  - else: idex_valid=id_valid, idex_rf_we=id_rf_we&id_valid, idex_op1/op2=resolved, idex_wR=id_wR.
- Bubble: op/wR fields keep their old values; only valid/we clear.
- Unused sources never cause a stall.
- stall_cnt increments on each cycle with stall=1 and wraps at 2^32.
- Latency: 1 cycle ID to ID/EX when no stall.

Optional Feature:
- Macro ID_FWD_EN (defined): forwarding as above.
- Undefined: no forwarding muxes; operands always rD, x0 reads 0.
- Without forwarding, hazard = id_valid and a used nonzero source matches any active writer in EX, MEM or WB.
- Stall repeats each cycle until clear: maximum 3 consecutive stall cycles per instruction.
- Flush priority and stall_cnt behave as above.

Decomposition:
- Shared param.v holds XLEN and RADDR defines, the x0 address constant, and the ID_FWD_EN default.
- One sub-module, fwd_mux: combinational per-operand match and priority select. Instantiated twice.

Test Plan:
- rD1=0x11, no writers active, rs1=3 -> idex_op1=0x11, idex_valid=1 one cycle later.
- EX writes x5=0xAAAA, MEM writes x5=0xBBBB, rs1=5 -> idex_op1=0xAAAA (EX priority). With ID_FWD_EN undefined -> stall for 3 cycles, then rD1.
- Only WB writes x7=0x1234, rD2 still old 0x0, rs2=7 -> idex_op2=0x1234.
- ex_is_load=1, ex_wR=9, rs1=9 used -> stall=1 one cycle, bubble in ID/EX, stall_cnt=1. Next cycle mem_wD=0x55 -> idex_op1=0x55.
- Same load-use with flush=1 -> stall=0, idex_valid=0. rs2=9 with rs2_used=0 -> no stall.
- Writer to x0 with wD=0xFFFF, rs1=0 -> idex_op1=0. Assert rst mid-stall -> all idex outputs and stall_cnt go to 0 immediately.
